wb_select_stage: RTL

Parametrised, registered writeback-select stage for the vector ASIP datapath. It replaces the fixed 2:1 scalar writeback mux. Each beat selects one of NUM_SRC sources for LANES lanes of N bits, applies a per-lane write mask, and registers the result toward the register-file write port (WD3/A3/WE3). A 2-entry skid buffer with valid/ready handshake absorbs register-file back-pressure without combinational ready paths.

---
 rtl/wb_select_stage_pkg.sv | 29 ++
 rtl/wb_select_stage_skid_buffer.sv | 55 +++++
 rtl/wb_select_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/wb_select_stage_pkg.sv
// Shared constants and types for the writeback-select stage.
package wb_pkg;

    // Source indices on the WBSelect bus
    localparam int WB_SEL_MEM = 0;
    localparam int WB_SEL_ALU = 1;
    localparam int WB_SEL_IMM = 2;

    // Default datapath configuration
    localparam int WB_N       = 32;
    localparam int WB_LANES   = 4;
    localparam int WB_NUM_SRC = 3;
    localparam int WB_ADDR_W  = 5;

    // One registered writeback beat in the default configuration. The stage
    // packs its payload in this same field order for any configuration.
    typedef struct packed {
        logic [WB_LANES*WB_N-1:0] data;
        logic [WB_ADDR_W-1:0]     addr;
        logic                     we;
        logic [WB_LANES-1:0]      mask;
    } wb_beat_t;

    // Select-bus width for a given source count, never narrower than one bit.
    function automatic int sel_width(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/wb_select_stage_skid_buffer.sv
// Two-entry valid/ready register pair. "main" drives the outputs; "skid"
// catches the beat that arrives in the cycle the consumer stalls, so that
// in_ready never depends combinationally on out_ready.
module wb_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;
    logic         accept;

    assign in_ready  = !skid_valid && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Advance the main/skid pair: fill, drain, or shift skid into main.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking '<=' so every register samples pre-edge values.
        if (rst) begin
            // NOTE: payload registers are cleared too, because the outputs must read zero after reset.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            // Full: upstream is held off, so the only event is a drain.
            if (out_ready) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (!main_valid || out_ready) begin
            // Empty or draining: main takes the incoming beat, if any.
            main_valid <= accept;
            if (accept) begin
                main_data <= in_data;
            end
        end else if (accept) begin
            // Stalled with one beat held: park the new beat in skid.
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/wb_select_stage.sv
// Registered writeback-select stage: picks one of NUM_SRC multi-lane sources,
// zeroes masked-off lanes and hands the beat to the register-file write port
// through a 2-entry skid buffer.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int N       = 32,
    parameter int LANES   = 4,
    parameter int NUM_SRC = 3,
    parameter int ADDR_W  = 5,
    localparam int SEL_W  = sel_width(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SEL_W-1:0]           WBSelect,
    input  logic [NUM_SRC*LANES*N-1:0] src_data,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic                       wr_en,
    input  logic [LANES-1:0]           lane_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*N-1:0]         WD3,
    output logic [ADDR_W-1:0]          A3,
    output logic                       WE3,
    output logic [LANES-1:0]           WM3,
    output logic                       sel_err
);
    localparam int DATA_W = LANES * N;
    localparam int PAY_W  = DATA_W + ADDR_W + 1 + LANES;

    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] masked_data;
    logic              sel_hit;
    logic              accept;
    logic [PAY_W-1:0]  in_payload;
    logic [PAY_W-1:0]  out_payload;

    // Select the addressed source and zero every masked-off lane.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        sel_data    = '0;
        sel_hit     = 1'b0;
        masked_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (WBSelect == SEL_W'(s)) begin
                sel_data = src_data[s*DATA_W +: DATA_W];
                sel_hit  = 1'b1;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (lane_mask[l]) begin
                masked_data[l*N +: N] = sel_data[l*N +: N];
            end
        end
    end

    assign accept     = in_valid && in_ready;
    assign in_payload = {masked_data, wr_addr, wr_en & (|lane_mask), lane_mask};

    // Sticky flag for any accepted beat whose select was out of range.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_hit) begin
            sel_err <= 1'b1;
        end
    end

    wb_skid_buffer #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {WD3, A3, WE3, WM3} = out_payload;

endmodule
